// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter: FSM states, grant ids and default widths.
package mem_arbiter_pkg;

   localparam int unsigned LineWDefault = 128;
   localparam int unsigned AddrWDefault = 32;

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   typedef enum logic [1:0] {GntIc, GntDcr, GntDcw} grant_e;

   function automatic logic is_read(grant_e g);
      return g != GntDcw;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: eviction first, then round-robin between the two fills.
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic   ic_req,
   input  logic   dcr_req,
   input  logic   dcw_req,
   input  grant_e last_grant,
   output grant_e grant,
   output logic   valid
);

   always_comb begin
      grant = GntIc;
      valid = ic_req | dcr_req | dcw_req;
      if (dcw_req) begin
         grant = GntDcw;
      end else if (ic_req && dcr_req) begin
         grant = (last_grant == GntIc) ? GntDcr : GntIc;
      end else if (dcr_req) begin
         grant = GntDcr;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache fills, dcache fills and dcache evictions onto one memory port,
// with one outstanding transaction and a mandatory idle cycle after every client ack.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned LINE_W = LineWDefault,
   parameter int unsigned ADDR_W = AddrWDefault
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_read_req,
   input  logic [ADDR_W-1:0] ic_read_addr,
   output logic [LINE_W-1:0] ic_read_data,
   output logic              ic_read_ack,
   input  logic              dc_read_req,
   input  logic [ADDR_W-1:0] dc_read_addr,
   output logic [LINE_W-1:0] dc_read_data,
   output logic              dc_read_ack,
   input  logic              dc_write_req,
   input  logic [ADDR_W-1:0] dc_write_addr,
   input  logic [LINE_W-1:0] dc_write_data,
   output logic              dc_write_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              busy
);

   state_e              state_q;
   grant_e              grant_q;
   grant_e              last_grant_q;
   logic [LINE_W-1:0]   rdata_q;
   grant_e              pick_grant;
   logic                pick_valid;
   logic [ADDR_W-1:0]   sel_addr;

   mem_arb_pick u_pick (
      .ic_req     (ic_read_req),
      .dcr_req    (dc_read_req),
      .dcw_req    (dc_write_req),
      .last_grant (last_grant_q),
      .grant      (pick_grant),
      .valid      (pick_valid)
   );

   always_comb begin
      sel_addr = ic_read_addr;
      unique case (pick_grant)
         GntDcr:  sel_addr = dc_read_addr;
         GntDcw:  sel_addr = dc_write_addr;
         default: sel_addr = ic_read_addr;
      endcase
   end

   // Both clients see the same line register; it is only meaningful during their ack.
   assign ic_read_data = rdata_q;
   assign dc_read_data = rdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         grant_q      <= GntIc;
         last_grant_q <= GntDcr;
         rdata_q      <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         busy         <= 1'b0;
         ic_read_ack  <= 1'b0;
         dc_read_ack  <= 1'b0;
         dc_write_ack <= 1'b0;
      end else begin
         ic_read_ack  <= 1'b0;
         dc_read_ack  <= 1'b0;
         dc_write_ack <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  grant_q   <= pick_grant;
                  mem_addr  <= sel_addr;
                  mem_wdata <= dc_write_data;
                  mem_we    <= (pick_grant == GntDcw);
                  if (is_read(pick_grant)) begin
                     last_grant_q <= pick_grant;
                  end
                  mem_req <= 1'b1;
                  busy    <= 1'b1;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (is_read(grant_q)) begin
                     rdata_q <= mem_rdata;
                  end
                  unique case (grant_q)
                     GntIc:   ic_read_ack  <= 1'b1;
                     GntDcr:  dc_read_ack  <= 1'b1;
                     default: dc_write_ack <= 1'b1;
                  endcase
                  state_q <= StResp;
               end
            end
            StResp: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a simple memory responder, clients that drop req on ack,
// and a standalone sweep of the grant picker.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int unsigned LW = 128;
   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_read_req, dc_read_req, dc_write_req;
   logic [AW-1:0] ic_read_addr, dc_read_addr, dc_write_addr;
   logic [LW-1:0] ic_read_data, dc_read_data, dc_write_data;
   logic          ic_read_ack, dc_read_ack, dc_write_ack;
   logic          mem_req, mem_we, mem_ack, busy;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata, mem_rdata;

   logic   pk_ic, pk_dcr, pk_dcw, pk_valid;
   grant_e pk_last, pk_grant;

   always #5 clk = ~clk;

   mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
      .clk           (clk),
      .reset         (reset),
      .ic_read_req   (ic_read_req),
      .ic_read_addr  (ic_read_addr),
      .ic_read_data  (ic_read_data),
      .ic_read_ack   (ic_read_ack),
      .dc_read_req   (dc_read_req),
      .dc_read_addr  (dc_read_addr),
      .dc_read_data  (dc_read_data),
      .dc_read_ack   (dc_read_ack),
      .dc_write_req  (dc_write_req),
      .dc_write_addr (dc_write_addr),
      .dc_write_data (dc_write_data),
      .dc_write_ack  (dc_write_ack),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ack       (mem_ack),
      .busy          (busy)
   );

   mem_arb_pick u_pick_tb (
      .ic_req     (pk_ic),
      .dcr_req    (pk_dcr),
      .dcw_req    (pk_dcw),
      .last_grant (pk_last),
      .grant      (pk_grant),
      .valid      (pk_valid)
   );

   typedef struct {
      int            client;
      logic          we;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
   } txn_t;

   txn_t exp_q[$];
   int checks = 0, errors = 0;
   int cyc = 0, mem_delay = 0, mem_cnt = 0;
   bit spur = 1'b0;
   logic          cap_we;
   logic [AW-1:0] cap_addr;
   logic [LW-1:0] cap_wdata;
   int start_cyc = 0, prev_ack_cyc = 0, last_ack_cyc = 0, last_gap = 0;
   int busy_cnt = 0, ack_cnt = 0;
   int ic_left = 0, dcr_left = 0, dcw_left = 0;

   task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
      return {4{32'hA5A5_A5A5 ^ a}};
   endfunction

   assign mem_rdata = line_of(mem_addr);

   function automatic txn_t mk(input int c, input logic we, input logic [AW-1:0] a,
                               input logic [LW-1:0] d);
      txn_t t;
      t.client = c;
      t.we     = we;
      t.addr   = a;
      t.wdata  = d;
      return t;
   endfunction

   // One cycle: sample at the falling edge, score acks, then drive client and memory inputs.
   task automatic step();
      int   n;
      int   who;
      txn_t e;
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (mem_req && mem_cnt == 0) begin
         cap_we    = mem_we;
         cap_addr  = mem_addr;
         cap_wdata = mem_wdata;
         start_cyc = cyc;
      end
      n = int'(ic_read_ack) + int'(dc_read_ack) + int'(dc_write_ack);
      if (n != 0) begin
         who = ic_read_ack ? 0 : (dc_read_ack ? 1 : 2);
         check_eq("ack_onehot", LW'(n), LW'(1));
         check_eq("ack_expected", LW'(exp_q.size() > 0), LW'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("ack_client", LW'(who), LW'(e.client));
            check_eq("mem_we", LW'(cap_we), LW'(e.we));
            check_eq("mem_addr", LW'(cap_addr), LW'(e.addr));
            if (e.we) check_eq("mem_wdata", cap_wdata, e.wdata);
            else check_eq("read_data", (who == 0) ? ic_read_data : dc_read_data, line_of(e.addr));
         end
         ack_cnt++;
         last_gap     = start_cyc - prev_ack_cyc;
         prev_ack_cyc = cyc;
         last_ack_cyc = cyc;
         case (who)
            0: begin ic_left--;  if (ic_left <= 0) ic_read_req = 1'b0; end
            1: begin dcr_left--; if (dcr_left <= 0) dc_read_req = 1'b0; end
            default: begin dcw_left--; if (dcw_left <= 0) dc_write_req = 1'b0; end
         endcase
      end
      if (mem_req) begin
         mem_ack = (mem_cnt == mem_delay);
         mem_cnt++;
      end else begin
         mem_ack = spur;
         mem_cnt = 0;
      end
   endtask

   task automatic wait_acks(input int target, input int budget, input string tag);
      int base;
      base = ack_cnt;
      for (int i = 0; i < budget && ack_cnt < base + target; i++) step();
      check_eq({tag, "_acks"}, LW'(ack_cnt - base), LW'(target));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int base;
      int req_cyc;
      grant_e want_g;
      reset = 1'b1;
      {ic_read_req, dc_read_req, dc_write_req, mem_ack} = '0;
      ic_read_addr = '0; dc_read_addr = '0; dc_write_addr = '0; dc_write_data = '0;
      {pk_ic, pk_dcr, pk_dcw} = '0;
      pk_last = GntDcr;
      do_reset();
      step();
      check_eq("rst_mem_req", LW'(mem_req), LW'(0));
      check_eq("rst_mem_we", LW'(mem_we), LW'(0));
      check_eq("rst_mem_addr", LW'(mem_addr), LW'(0));
      check_eq("rst_mem_wdata", mem_wdata, '0);
      check_eq("rst_busy", LW'(busy), LW'(0));
      check_eq("rst_acks", LW'({ic_read_ack, dc_read_ack, dc_write_ack}), LW'(0));
      check_eq("rst_ic_data", ic_read_data, '0);
      check_eq("rst_dc_data", dc_read_data, '0);

      // Grant picker truth table
      for (int i = 0; i < 16; i++) begin
         pk_ic   = i[0];
         pk_dcr  = i[1];
         pk_dcw  = i[2];
         pk_last = i[3] ? GntIc : GntDcr;
         #1;
         if (pk_dcw) want_g = GntDcw;
         else if (pk_ic && pk_dcr) want_g = i[3] ? GntDcr : GntIc;
         else if (pk_dcr) want_g = GntDcr;
         else want_g = GntIc;
         check_eq("pick_valid", LW'(pk_valid), LW'(i[2:0] != 3'b000));
         if (i[2:0] != 3'b000) check_eq("pick_grant", LW'(pk_grant), LW'(want_g));
      end

      // Single icache fill, memory answers on the fourth request cycle
      mem_delay = 3;
      exp_q.push_back(mk(0, 1'b0, 32'h100, '0));
      ic_read_addr = 32'h100; ic_left = 1; ic_read_req = 1'b1;
      wait_acks(1, 30, "t1");
      check_eq("t1_ack_lat", LW'(last_ack_cyc - start_cyc), LW'(4));

      // Eviction beats the same-cycle dcache fill, then one idle cycle before the fill
      step();
      mem_delay = 1;
      exp_q.push_back(mk(2, 1'b1, 32'h200, {4{32'hDEAD_BEEF}}));
      exp_q.push_back(mk(1, 1'b0, 32'h300, '0));
      dc_write_addr = 32'h200; dc_write_data = {4{32'hDEAD_BEEF}}; dcw_left = 1;
      dc_read_addr = 32'h300; dcr_left = 1;
      dc_write_req = 1'b1; dc_read_req = 1'b1;
      wait_acks(2, 40, "t2");
      check_eq("t2_idle_gap", LW'(last_gap), LW'(2));

      // Both fills held from reset: grants alternate IC, DC, IC, DC
      do_reset();
      mem_delay = 0;
      exp_q.push_back(mk(0, 1'b0, 32'h40, '0));
      exp_q.push_back(mk(1, 1'b0, 32'h80, '0));
      exp_q.push_back(mk(0, 1'b0, 32'h40, '0));
      exp_q.push_back(mk(1, 1'b0, 32'h80, '0));
      ic_read_addr = 32'h40; dc_read_addr = 32'h80; ic_left = 2; dcr_left = 2;
      ic_read_req = 1'b1; dc_read_req = 1'b1;
      wait_acks(4, 60, "t3");

      // Immediate memory ack: minimum latency and busy width
      step();
      busy_cnt = 0;
      exp_q.push_back(mk(0, 1'b0, 32'h600, '0));
      ic_read_addr = 32'h600; ic_left = 1; ic_read_req = 1'b1;
      req_cyc = cyc;
      wait_acks(1, 20, "t4");
      check_eq("t4_req_to_ack", LW'(last_ack_cyc - req_cyc), LW'(2));
      step();
      step();
      check_eq("t4_busy_cycles", LW'(busy_cnt), LW'(2));

      // Reset during ISSUE abandons the transaction
      mem_delay = 50;
      exp_q.push_back(mk(0, 1'b0, 32'h700, '0));
      ic_read_addr = 32'h700; ic_left = 1; ic_read_req = 1'b1;
      for (int i = 0; i < 10 && !mem_req; i++) step();
      check_eq("t5_in_issue", LW'(mem_req), LW'(1));
      step();
      reset = 1'b1;
      ic_read_req = 1'b0;
      exp_q.delete();
      base = ack_cnt;
      step();
      reset = 1'b0;
      check_eq("t5_mem_req", LW'(mem_req), LW'(0));
      check_eq("t5_busy", LW'(busy), LW'(0));
      for (int i = 0; i < 5; i++) step();
      check_eq("t5_no_ack", LW'(ack_cnt - base), LW'(0));
      mem_delay = 2;
      exp_q.push_back(mk(1, 1'b0, 32'h500, '0));
      dc_read_addr = 32'h500; dcr_left = 1; dc_read_req = 1'b1;
      wait_acks(1, 30, "t5_after");

      // Spurious mem_ack while idle is ignored
      step();
      base = ack_cnt;
      spur = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("t6_busy", LW'(busy), LW'(0));
         check_eq("t6_mem_req", LW'(mem_req), LW'(0));
      end
      spur = 1'b0;
      step();
      step();
      check_eq("t6_no_ack", LW'(ack_cnt - base), LW'(0));
      check_eq("scoreboard_empty", LW'(exp_q.size()), LW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (line fills only) and the data cache (line fills and dirty-line evictions).
- Sits between the two direct-mapped cache instances and the memory model.
- Accepts level-held req / one-cycle ack handshakes from the caches and serialises them into one outstanding memory transaction at a time.
- Priority order: data-cache eviction first, then round-robin between the two fill requests.

Parameters:
LINE_W, `WIDTH, bits per cache line / memory transfer
ADDR_W, `REG_SIZE, address width
(No others. Address is passed through unmodified; caches supply line-aligned addresses.)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- ic_read_req  in  1  icache fill request, held until ack
- ic_read_addr  in  ADDR_W  icache fill address
- ic_read_data  out  LINE_W  fill data, valid while ic_read_ack=1
- ic_read_ack  out  1  one-cycle completion pulse
- dc_read_req  in  1  dcache fill request
- dc_read_addr  in  ADDR_W  dcache fill address
- dc_read_data  out  LINE_W  fill data, valid while dc_read_ack=1
- dc_read_ack  out  1  one-cycle completion pulse
- dc_write_req  in  1  dcache eviction request
- dc_write_addr  in  ADDR_W  eviction address
- dc_write_data  in  LINE_W  evicted line
- dc_write_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory transaction valid, held until mem_ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  latched transaction address
- mem_wdata  out  LINE_W  latched write data
- mem_rdata  in  LINE_W  read data, sampled when mem_ack=1
- mem_ack  in  1  memory completion, sampled on rising edge
- busy  out  1  1 when state != IDLE

Behaviour:
- Reset (sync): state=IDLE, last_grant=DC; every output 0, including mem_addr, mem_wdata and the rdata register. Reset mid-transaction abandons it: mem_req drops after the reset edge and no client ack is produced. Memory must tolerate an abandoned request.
- FSM states are IDLE, ISSUE, RESP.
- IDLE:
  - Arbitration on each edge, in this priority order:
    1. dc_write_req wins unconditionally.
    2. If only one read request is pending, it wins.
    3. If both are pending, grant the client that is not last_grant.
  - On grant: latch grant id, addr, wdata and we; update last_grant (reads only); go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: mem_req=1 with latched fields held stable. On an edge with mem_ack=1: latch mem_rdata (reads), go to RESP. Otherwise stay in ISSUE; there is no timeout.
- RESP: exactly one cycle. Drive the granted client's ack=1; the read data output carries the latched line. Then go to IDLE unconditionally.
  - The IDLE cycle after RESP is mandatory, because clients drop req combinationally on ack and must not be re-granted.
- Latency: request seen at edge N → mem_req high cycles N+1.. → ack in the cycle after the mem_ack edge. Minimum req-to-ack is 2 cycles; minimum back-to-back spacing between grants is 3 cycles.
- ic/dc read_data hold their last value outside ack; they are meaningful only during ack.
- mem_ack in IDLE or RESP is ignored.
- Client drops req while in ISSUE: the transaction completes and the ack pulse is still issued (harmless).
- Requests arriving in ISSUE/RESP wait, since they are level-held.
- Data-cache ordering: an eviction and the dcache fill are both pending in the same cycle; write goes first, and the fill is granted no earlier than the next IDLE. This matches the cache's rule that a fill is not accepted while its write is pending.
- An icache request pending in that same IDLE competes with the dcache fill by round-robin.
- Starvation: the write has fixed priority; each dcache miss produces at most one eviction, so reads stay bounded.

Decomposition:
- Shared header mem_arbiter_defs.v (with include guard, includes define.v) holds:
  - state encodings ST_IDLE / ST_ISSUE / ST_RESP (2 bits);
  - grant ids GNT_IC / GNT_DCR / GNT_DCW.
- One combinational sub-module, mem_arb_pick. It takes the three reqs plus last_grant and returns a grant id and a valid signal. It is tested standalone for the priority table.
- Everything else lives in mem_arbiter.

Test Plan:
- Single icache fill to 0x100, memory acks 3 cycles after mem_req → mem_we=0, mem_addr=0x100, ic_read_ack one cycle later with line 0xA5.., dc acks stay 0.
- dc_write_req (0x200, data D) and dc_read_req (0x300) raised the same cycle → write transaction first with mem_we=1 and mem_wdata=D, dc_write_ack, one IDLE cycle, then read of 0x300 and dc_read_ack.
- ic and dc read requests held continuously for 4 transactions after reset → grants alternate IC, DC, IC, DC.
- Memory acks in the same cycle mem_req rises → ack appears exactly 2 cycles after the request edge; busy is high for 2 cycles.
- reset asserted while in ISSUE → next cycle mem_req=0, busy=0, no ack pulse; a subsequent request is served normally.
- Spurious mem_ack while IDLE → no state change and no client ack.
